// File: rtl/serial_adder_if.sv
// Start/Busy/Done handshake and operand/result bus
// for the bit-serial adder.
interface serial_adder_if #(
   parameter int WIDTH = 8
);
   logic             Start;
   logic [WIDTH-1:0] A_In;
   logic [WIDTH-1:0] B_In;
   logic             Busy;
   logic             Done;
   logic [WIDTH-1:0] Sum_Out;
   logic             Carry_Out;

   modport master (
      output Start, A_In, B_In,
      input  Busy, Done, Sum_Out, Carry_Out
   );

   modport slave (
      input  Start, A_In, B_In,
      output Busy, Done, Sum_Out, Carry_Out
   );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder, LSB first, one bit per clock,
// full adder built from two half_adder cells.
module half_adder (
   input  logic a,
   input  logic b,
   output logic s,
   output logic c
);
   assign s = a ^ b;
   assign c = a & b;
endmodule

module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic           Clk,
   input  logic           Rst,
   serial_adder_if.slave  bus
);
   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } state_t;

   state_t           state;
   state_t           state_nx;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [WIDTH-1:0] psum;
   logic [WIDTH-1:0] sum_q;
   logic [CW-1:0]    cnt;
   logic             carry;
   logic             carry_q;
   logic             s1;
   logic             c1;
   logic             s2;
   logic             c2;
   logic             c_nx;
   logic             last;

   half_adder ha0 (.a(a_sr[0]), .b(b_sr[0]), .s(s1), .c(c1));
   half_adder ha1 (.a(s1), .b(carry), .s(s2), .c(c2));

   assign c_nx = c1 | c2;
   assign last = (cnt == CW'(WIDTH - 1));

   always_ff @(posedge Clk) begin
      if (Rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (bus.Start) state_nx = SHIFT;
         SHIFT:   if (last) state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         a_sr    <= '0;
         b_sr    <= '0;
         psum    <= '0;
         carry   <= 1'b0;
         cnt     <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
      end else if (state == IDLE) begin
         if (bus.Start) begin
            a_sr  <= bus.A_In;
            b_sr  <= bus.B_In;
            carry <= 1'b0;
            cnt   <= '0;
         end
      end else if (state == SHIFT) begin
         a_sr  <= {1'b0, a_sr[WIDTH-1:1]};
         b_sr  <= {1'b0, b_sr[WIDTH-1:1]};
         psum  <= {s2, psum[WIDTH-1:1]};
         carry <= c_nx;
         cnt   <= cnt + 1'b1;
         // final bit goes straight into the result register
         if (last) begin
            sum_q   <= {s2, psum[WIDTH-1:1]};
            carry_q <= c_nx;
         end
      end
   end

   assign bus.Busy      = (state != IDLE);
   assign bus.Done      = (state == DONE);
   assign bus.Sum_Out   = sum_q;
   assign bus.Carry_Out = carry_q;
endmodule

// File: tb/tb_serial_adder.sv
// Directed and random checks for serial_adder, WIDTH=8.
// Outputs sampled 1 time unit after the rising edge.
module tb_serial_adder;
   logic clk;
   logic rst;
   int   checks;
   int   errors;

   serial_adder_if #(.WIDTH(8)) bus ();

   serial_adder #(.WIDTH(8)) dut (
      .Clk (clk),
      .Rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag,
                        input logic [63:0] got,
                        input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   // Launch one add and watch it until Busy falls (bounded).
   task automatic do_add(input  logic [7:0] a,
                         input  logic [7:0] b,
                         output int lat,
                         output int bcnt,
                         output int dcnt);
      @(negedge clk);
      bus.Start = 1'b1;
      bus.A_In  = a;
      bus.B_In  = b;
      @(posedge clk);
      #1;
      bus.Start = 1'b0;
      lat  = -1;
      bcnt = 0;
      dcnt = 0;
      for (int k = 0; k < 40; k++) begin
         if (bus.Busy) bcnt++;
         if (bus.Done) begin
            dcnt++;
            if (lat < 0) lat = k;
         end
         if (!bus.Busy) break;
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      int lat;
      int bcnt;
      int dcnt;
      int bad;
      int d1;
      int d2;
      logic [7:0] ra;
      logic [7:0] rb;

      checks    = 0;
      errors    = 0;
      rst       = 1'b1;
      bus.Start = 1'b0;
      bus.A_In  = '0;
      bus.B_In  = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_busy", 64'(bus.Busy), 64'd0);
      check("rst_done", 64'(bus.Done), 64'd0);
      check("rst_sum", 64'(bus.Sum_Out), 64'h0);
      check("rst_cy", 64'(bus.Carry_Out), 64'd0);
      rst = 1'b0;

      do_add(8'h0F, 8'h01, lat, bcnt, dcnt);
      check("0f01_sum", 64'(bus.Sum_Out), 64'h10);
      check("0f01_cy", 64'(bus.Carry_Out), 64'd0);
      check("0f01_lat", 64'(lat), 64'd8);
      check("0f01_busy", 64'(bcnt), 64'd9);
      check("0f01_done", 64'(dcnt), 64'd1);

      do_add(8'hFF, 8'h01, lat, bcnt, dcnt);
      check("ff01_sum", 64'(bus.Sum_Out), 64'h00);
      check("ff01_cy", 64'(bus.Carry_Out), 64'd1);

      do_add(8'hFF, 8'hFF, lat, bcnt, dcnt);
      check("ffff_sum", 64'(bus.Sum_Out), 64'hFE);
      check("ffff_cy", 64'(bus.Carry_Out), 64'd1);

      // Start pulses during SHIFT and DONE are ignored
      @(negedge clk);
      bus.Start = 1'b1;
      bus.A_In  = 8'h03;
      bus.B_In  = 8'h04;
      @(posedge clk);
      #1;
      bus.Start = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      bus.Start = 1'b1;
      bus.A_In  = 8'h55;
      bus.B_In  = 8'h55;
      @(posedge clk);
      #1;
      bus.Start = 1'b0;
      check("ign_sum_hold", 64'(bus.Sum_Out), 64'hFE);
      lat = -1;
      for (int k = 0; k < 10; k++) begin
         if (bus.Done) begin
            lat = k;
            break;
         end
         @(posedge clk);
         #1;
      end
      check("ign_done_seen", 64'(lat), 64'd4);
      @(negedge clk);
      bus.Start = 1'b1;
      @(posedge clk);
      #1;
      bus.Start = 1'b0;
      check("ign_busy", 64'(bus.Busy), 64'd0);
      check("ign_done", 64'(bus.Done), 64'd0);
      repeat (3) @(posedge clk);
      #1;
      check("ign_idle", 64'(bus.Busy), 64'd0);
      check("ign_sum", 64'(bus.Sum_Out), 64'h07);
      check("ign_cy", 64'(bus.Carry_Out), 64'd0);

      // Reset at E4 aborts the add
      @(negedge clk);
      bus.Start = 1'b1;
      bus.A_In  = 8'hAA;
      bus.B_In  = 8'h55;
      @(posedge clk);
      #1;
      bus.Start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("abort_busy", 64'(bus.Busy), 64'd0);
      check("abort_done", 64'(bus.Done), 64'd0);
      check("abort_sum", 64'(bus.Sum_Out), 64'h0);
      check("abort_cy", 64'(bus.Carry_Out), 64'd0);
      dcnt = 0;
      for (int k = 0; k < 12; k++) begin
         @(posedge clk);
         #1;
         if (bus.Done || bus.Busy) dcnt++;
      end
      check("abort_quiet", 64'(dcnt), 64'd0);

      // Back-to-back with Start held high
      @(negedge clk);
      bus.Start = 1'b1;
      bus.A_In  = 8'h10;
      bus.B_In  = 8'h20;
      @(posedge clk);
      #1;
      bus.A_In = 8'h01;
      bus.B_In = 8'h01;
      d1  = -1;
      d2  = -1;
      bad = 0;
      for (int k = 0; k < 25; k++) begin
         if (k == 10) bus.Start = 1'b0;
         if (bus.Done) begin
            if (d1 < 0) d1 = k;
            else if (d2 < 0) d2 = k;
         end
         if (d1 >= 0 && d2 < 0 && bus.Sum_Out != 8'h30) bad++;
         @(posedge clk);
         #1;
      end
      bus.Start = 1'b0;
      check("b2b_d1", 64'(d1), 64'd8);
      check("b2b_gap", 64'(d2 - d1), 64'd10);
      check("b2b_hold", 64'(bad), 64'd0);
      check("b2b_sum", 64'(bus.Sum_Out), 64'h02);
      check("b2b_cy", 64'(bus.Carry_Out), 64'd0);

      for (int n = 0; n < 1000; n++) begin
         ra = 8'($urandom);
         rb = 8'($urandom);
         do_add(ra, rb, lat, bcnt, dcnt);
         check("rand_res", 64'({bus.Carry_Out, bus.Sum_Out}),
               64'({1'b0, ra} + {1'b0, rb}));
         check("rand_pulse", 64'(dcnt), 64'd1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
